// File: rtl/mil_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : mil_pkg                                                  |
// | Description : Shared types and timing helpers for the Manchester-II    |
// |               line stages: FSM state encoding, line-state codes and    |
// |               the half-bit (TH) / quarter-bit (H2) clock counts.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package mil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC1 = 3'd1,
    ST_SYNC2 = 3'd2,
    ST_BITS  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Code is {RXN, RXP}, so decoding the synchronised pair is a direct map.
  typedef enum logic [1:0] {
    LN_Z = 2'b00,  // both low: idle line
    LN_P = 2'b01,  // positive half
    LN_N = 2'b10,  // negative half
    LN_X = 2'b11   // both high: illegal
  } line_e;

  // Half-bit length in clocks; identical to the transmitter's TH.
  function automatic int calc_th(input int fclk, input int rxvel);
    return fclk / (2 * rxvel);
  endfunction

  function automatic int calc_h2(input int th);
    return th / 2;
  endfunction

  // Opposite polarity; Z and X have no opposite and map to themselves.
  function automatic line_e opp(input line_e l);
    case (l)
      LN_P:    return LN_N;
      LN_N:    return LN_P;
      default: return l;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mil_rxd_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : mil_rxd_if                                               |
// | Description : Line pair in, decoded word and status out.               |
// |   RXP/RXN        line comparators (asynchronous to clk)                |
// |   rx_dat[15:0]   received word, held until the next rx_rdy             |
// |   rx_cw          1 = command/status sync, 0 = data sync                |
// |   rx_rdy         1-clk pulse: good word                                |
// |   rx_err         1-clk pulse: aborted word or bad parity               |
// |   err_par/man    error cause, held until the next rdy/err              |
// |   rx_busy        word in progress                                      |
// |   master = line driver / word consumer, slave = receiver               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface mil_rxd_if;
  logic        RXP;
  logic        RXN;
  logic [15:0] rx_dat;
  logic        rx_cw;
  logic        rx_rdy;
  logic        rx_err;
  logic        err_par;
  logic        err_man;
  logic        rx_busy;

  modport master (
    output RXP, RXN,
    input  rx_dat, rx_cw, rx_rdy, rx_err, err_par, err_man, rx_busy
  );

  modport slave (
    input  RXP, RXN,
    output rx_dat, rx_cw, rx_rdy, rx_err, err_par, err_man, rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/mil_rx_line.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mil_rx_line                                              |
// | Description : Brings the asynchronous comparator pair into the clk     |
// |               domain and decodes it to Z/P/N/X (two clocks latency).   |
// |   clk, rst   clock, synchronous active-high reset                      |
// |   rxp_i      positive comparator                                       |
// |   rxn_i      negative comparator                                       |
// |   line_o     registered line state                                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mil_rx_line
  import mil_pkg::*;
(
  input  wire   clk,
  input  wire   rst,
  input  wire   rxp_i,
  input  wire   rxn_i,
  output line_e line_o
);

  logic [1:0] meta_q;
  line_e      line_q;

  // Second synchroniser stage doubles as the decode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 2'b00;
      line_q <= LN_Z;
    end else begin
      meta_q <= {rxn_i, rxp_i};
      line_q <= line_e'(meta_q);
    end
  end

  assign line_o = line_q;

endmodule
`default_nettype wire

// File: rtl/mil_rxd.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mil_rxd                                                  |
// | Description : Manchester-II receiver: 3-bit sync detection, 16 data    |
// |               bits MSB first plus odd parity, ready/error strobes.     |
// |   clk, rst   clock, synchronous active-high reset                      |
// |   bus        mil_rxd_if.slave (line in, word and status out)           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mil_rxd
  import mil_pkg::*;
#(
  parameter int RXvel = 1000000,
  parameter int Fclk  = 50000000
) (
  input  wire         clk,
  input  wire         rst,
  mil_rxd_if.slave    bus
);

  localparam int TH = calc_th(Fclk, RXvel);
  localparam int H2 = calc_h2(TH);

  localparam logic [6:0] c_TH      = 7'(TH);
  localparam logic [6:0] c_H2      = 7'(H2);
  localparam logic [6:0] c_SYNC_LO = 7'(3 * TH - H2);
  localparam logic [6:0] c_SYNC_HI = 7'(3 * TH + H2);
  // First data bit: mid edge 4TH after the mid-sync edge; later bits 2TH.
  localparam logic [6:0] c_E0_LO   = 7'(4 * TH - H2);
  localparam logic [6:0] c_E0_HI   = 7'(4 * TH + H2);
  localparam logic [6:0] c_E1_LO   = 7'(2 * TH - H2);
  localparam logic [6:0] c_E1_HI   = 7'(2 * TH + H2);
  localparam logic [4:0] c_K_DONE  = 5'd17;

  line_e       w_line;
  logic        w_pn;
  logic [6:0]  ph_d;
  logic [6:0]  w_e_lo;
  logic [6:0]  w_e_hi;
  logic        w_bit;
  logic        w_samp_a;
  logic        w_edge;
  logic        w_samp_b;
  logic        w_man_err;

  state_e      state_q;
  line_e       s_q;
  line_e       a_q;
  logic [6:0]  l_q;
  logic [6:0]  ph_q;
  logic [4:0]  k_q;
  logic        first_q;
  logic        got_a_q;
  logic        got_edge_q;
  logic [15:0] sr_q;
  logic        par_q;
  logic        cw_sh_q;
  logic [15:0] dat_q;
  logic        cw_q;
  logic        rdy_q;
  logic        err_q;
  logic        epar_q;
  logic        eman_q;
  logic        busy_q;

  mil_rx_line u_line (
    .clk    (clk),
    .rst    (rst),
    .rxp_i  (bus.RXP),
    .rxn_i  (bus.RXN),
    .line_o (w_line)
  );

  assign w_pn   = (w_line == LN_P) || (w_line == LN_N);
  assign ph_d   = ph_q + 7'd1;
  assign w_e_lo = first_q ? c_E0_LO : c_E1_LO;
  assign w_e_hi = first_q ? c_E0_HI : c_E1_HI;
  assign w_bit  = (a_q == LN_P);

  // Per-bit event decode: sample A, mid-bit edge, sample B, or violation.
  always_comb begin
    w_samp_a  = 1'b0;
    w_edge    = 1'b0;
    w_samp_b  = 1'b0;
    w_man_err = 1'b0;
    if (state_q == ST_BITS && k_q != c_K_DONE) begin
      if (!got_a_q) begin
        if (ph_d == w_e_lo) begin
          if (w_pn) w_samp_a  = 1'b1;
          else      w_man_err = 1'b1;
        end
      end else if (!got_edge_q) begin
        // Edge is checked first so a transition exactly at E+H2 is accepted.
        if (w_line == opp(a_q))  w_edge    = 1'b1;
        else if (ph_d == w_e_hi) w_man_err = 1'b1;
      end else if (ph_d == c_H2) begin
        if (w_line == opp(a_q)) w_samp_b  = 1'b1;
        else                    w_man_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_q        <= LN_Z;
      a_q        <= LN_Z;
      l_q        <= '0;
      ph_q       <= '0;
      k_q        <= '0;
      first_q    <= 1'b0;
      got_a_q    <= 1'b0;
      got_edge_q <= 1'b0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      cw_sh_q    <= 1'b0;
      dat_q      <= '0;
      cw_q       <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      epar_q     <= 1'b0;
      eman_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_pn) begin
            l_q     <= 7'd1;
            s_q     <= w_line;
            state_q <= ST_SYNC1;
          end
        end

        ST_SYNC1: begin
          if (w_line == s_q) begin
            if (l_q != 7'd127) l_q <= l_q + 7'd1;
          end else if (w_line == opp(s_q) && l_q >= c_SYNC_LO && l_q <= c_SYNC_HI) begin
            ph_q    <= '0;
            cw_sh_q <= (s_q == LN_P);
            state_q <= ST_SYNC2;
          end else if (w_pn) begin
            // Rejected run of one polarity may be the start of a real sync.
            l_q <= 7'd1;
            s_q <= w_line;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_SYNC2: begin
          ph_q <= ph_d;
          if (w_line != opp(s_q)) begin
            if (w_pn) begin
              l_q     <= 7'd1;
              s_q     <= w_line;
              state_q <= ST_SYNC1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (ph_d == c_SYNC_LO) begin
            busy_q     <= 1'b1;
            k_q        <= '0;
            first_q    <= 1'b1;
            got_a_q    <= 1'b0;
            got_edge_q <= 1'b0;
            par_q      <= 1'b0;
            state_q    <= ST_BITS;
          end
        end

        ST_BITS: begin
          ph_q <= ph_d;
          if (k_q == c_K_DONE) begin
            busy_q  <= 1'b0;
            state_q <= ST_GAP;
            eman_q  <= 1'b0;
            if (par_q) begin
              dat_q  <= sr_q;
              cw_q   <= cw_sh_q;
              rdy_q  <= 1'b1;
              epar_q <= 1'b0;
            end else begin
              err_q  <= 1'b1;
              epar_q <= 1'b1;
            end
          end else if (w_man_err) begin
            err_q   <= 1'b1;
            eman_q  <= 1'b1;
            epar_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (w_samp_a) begin
            a_q     <= w_line;
            got_a_q <= 1'b1;
          end else if (w_edge) begin
            ph_q       <= '0;
            got_edge_q <= 1'b1;
            first_q    <= 1'b0;
          end else if (w_samp_b) begin
            // Bits 0..15 are data; bit 16 only feeds the parity sum.
            if (!k_q[4]) sr_q <= {sr_q[14:0], w_bit};
            par_q      <= par_q ^ w_bit;
            k_q        <= k_q + 5'd1;
            got_a_q    <= 1'b0;
            got_edge_q <= 1'b0;
          end
        end

        ST_GAP: begin
          ph_q <= ph_d;
          // End of the parity bit: a polarity here is the first sync cycle
          // of a back-to-back word, even if it continues the parity half.
          if (ph_d == c_TH) begin
            if (w_pn) begin
              l_q     <= 7'd1;
              s_q     <= w_line;
              state_q <= ST_SYNC1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_dat  = dat_q;
  assign bus.rx_cw   = cw_q;
  assign bus.rx_rdy  = rdy_q;
  assign bus.rx_err  = err_q;
  assign bus.err_par = epar_q;
  assign bus.err_man = eman_q;
  assign bus.rx_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mil_rxd.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mil_rxd                                               |
// | Description : Self-checking bench for mil_rxd: table of words plus     |
// |               hand-built sync, back-to-back and reset sequences;       |
// |               expected events queued at stimulus, checked on strobe.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mil_rxd;

  localparam int TH = 25;
  localparam int H2 = 12;
  // Parity mid-edge driven on a falling edge -> strobe seen on a falling edge:
  // H2+1 decode clocks, 2 synchroniser clocks, plus the half-cycle offsets.
  localparam int RDY_LAT = H2 + 1 + 2 + 1;

  typedef struct {
    logic        is_err;
    logic [15:0] dat;
    logic        cw;
    logic        par;
    logic        man;
    logic        chk_lat;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    logic        cw;
    logic        flip;
    int          man;
    logic        e_err;
    logic [15:0] e_dat;
    logic        e_cw;
    logic        e_par;
    logic        e_man;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_evt = 0;
  int   par_edge_cyc = 0;
  logic busy_seen = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[6];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mil_rxd_if bus();

  mil_rxd #(.RXvel(1000000), .Fclk(50000000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic n, input int cycles);
    bus.RXP = p;
    bus.RXN = n;
    repeat (cycles) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.rx_busy;
    end
  endtask

  // v = 1 drives P, v = 0 drives N.
  task automatic sym(input logic v, input int cycles);
    drive(v, !v, cycles);
  endtask

  task automatic push(input logic is_err, input logic [15:0] dat, input logic cw,
                      input logic par, input logic man, input logic chk_lat);
    exp_t e;
    e.is_err = is_err; e.dat = dat; e.cw = cw;
    e.par = par; e.man = man; e.chk_lat = chk_lat;
    sb.push_back(e);
  endtask

  // man_bit: that bit is held at one polarity for a whole bit time, then stop.
  // stop_bit: stop partway through the first half of that bit.
  task automatic send_word(input logic [15:0] w, input logic cw, input logic flip,
                           input int man_bit, input int stop_bit);
    logic [16:0] bits;
    bits = {w, (~(^w)) ^ flip};
    sym(cw, 3 * TH);
    sym(!cw, 3 * TH);
    for (int i = 0; i < 17; i++) begin
      if (i == man_bit) begin
        sym(bits[16-i], 2 * TH);
        return;
      end
      if (i == stop_bit) begin
        sym(bits[16-i], H2);
        return;
      end
      sym(bits[16-i], TH);
      if (i == 16) par_edge_cyc = cyc;
      sym(!bits[16-i], TH);
      if (i == 2) check("busy_in_word", bus.rx_busy, 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dat"},  bus.rx_dat, 0);
    check({tag, "_cw"},   bus.rx_cw, 0);
    check({tag, "_rdy"},  bus.rx_rdy, 0);
    check({tag, "_err"},  bus.rx_err, 0);
    check({tag, "_epar"}, bus.err_par, 0);
    check({tag, "_eman"}, bus.err_man, 0);
    check({tag, "_busy"}, bus.rx_busy, 0);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.rx_rdy || bus.rx_err)) begin
      n_evt++;
      check("rdy_err_exclusive", bus.rx_rdy & bus.rx_err, 0);
      check("event_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("ev_kind_err", bus.rx_err, mon_e.is_err);
        check("ev_dat",      bus.rx_dat, mon_e.dat);
        check("ev_cw",       bus.rx_cw, mon_e.cw);
        check("ev_err_par",  bus.err_par, mon_e.par);
        check("ev_err_man",  bus.err_man, mon_e.man);
        if (mon_e.chk_lat) check("ev_latency", cyc - par_edge_cyc, RDY_LAT);
      end
    end
  end

  initial begin
    int ev0;
    tbl[0] = '{w:16'h1234, cw:1'b1, flip:1'b0, man:-1, e_err:1'b0, e_dat:16'h1234, e_cw:1'b1, e_par:1'b0, e_man:1'b0};
    tbl[1] = '{w:16'hFFFF, cw:1'b0, flip:1'b0, man:-1, e_err:1'b0, e_dat:16'hFFFF, e_cw:1'b0, e_par:1'b0, e_man:1'b0};
    tbl[2] = '{w:16'h1234, cw:1'b1, flip:1'b1, man:-1, e_err:1'b1, e_dat:16'hFFFF, e_cw:1'b0, e_par:1'b1, e_man:1'b0};
    tbl[3] = '{w:16'hA5C3, cw:1'b1, flip:1'b0, man:5,  e_err:1'b1, e_dat:16'hFFFF, e_cw:1'b0, e_par:1'b0, e_man:1'b1};
    tbl[4] = '{w:16'h0000, cw:1'b0, flip:1'b0, man:-1, e_err:1'b0, e_dat:16'h0000, e_cw:1'b0, e_par:1'b0, e_man:1'b0};
    tbl[5] = '{w:16'h8001, cw:1'b1, flip:1'b0, man:-1, e_err:1'b0, e_dat:16'h8001, e_cw:1'b1, e_par:1'b0, e_man:1'b0};

    bus.RXP = 1'b0;
    bus.RXN = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    drive(0, 0, 20);

    // Table-driven words, each followed by an idle gap.
    for (int v = 0; v < 6; v++) begin
      push(tbl[v].e_err, tbl[v].e_dat, tbl[v].e_cw, tbl[v].e_par, tbl[v].e_man, tbl[v].man < 0);
      send_word(tbl[v].w, tbl[v].cw, tbl[v].flip, tbl[v].man, -1);
      drive(0, 0, 60);
      check("busy_after_word", bus.rx_busy, 0);
    end
    check("table_events_drained", sb.size(), 0);

    // Malformed syncs: out-of-window halves, X in first half, X in second half.
    busy_seen = 1'b0;
    ev0 = n_evt;
    sym(1, 40); sym(0, 40); drive(0, 0, 30);
    sym(1, 95); sym(0, 95); drive(0, 0, 30);
    sym(1, 30); drive(1, 1, 5); sym(1, 40); sym(0, 75); drive(0, 0, 30);
    sym(1, 75); sym(0, 30); drive(1, 1, 10); drive(0, 0, 30);
    check("badsync_busy", busy_seen, 0);
    check("badsync_events", n_evt - ev0, 0);

    // Back-to-back: parity half P then data sync N.
    push(0, 16'h0001, 1, 0, 0, 1);
    push(0, 16'h5A5A, 0, 0, 0, 1);
    send_word(16'h0001, 1, 0, -1, -1);
    send_word(16'h5A5A, 0, 0, -1, -1);
    drive(0, 0, 60);
    // Back-to-back with merged N run of 4TH (parity 1 ends N, data sync N).
    push(0, 16'h0003, 1, 0, 0, 1);
    push(0, 16'h00FF, 0, 0, 0, 1);
    send_word(16'h0003, 1, 0, -1, -1);
    send_word(16'h00FF, 0, 0, -1, -1);
    drive(0, 0, 60);
    check("b2b_events_drained", sb.size(), 0);

    // Reset during bit 8 abandons the word silently.
    ev0 = n_evt;
    send_word(16'h1234, 1, 0, -1, 8);
    check("busy_before_rst", bus.rx_busy, 1);
    rst = 1'b1;
    drive(0, 0, 3);
    check_all_zero("midrst");
    rst = 1'b0;
    drive(0, 0, 40);
    check("midrst_events", n_evt - ev0, 0);
    check("midrst_dat_after", bus.rx_dat, 0);
    push(0, 16'hBEEF, 0, 0, 0, 1);
    send_word(16'hBEEF, 0, 0, -1, -1);
    drive(0, 0, 60);

    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
